// File: rtl/prog_mem_pkg.sv
// Shared types and default geometry for the loadable program memory.
package prog_mem_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DEPTH_DEF  = 32;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Index width needed to address DEPTH words (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x DATA_W single-port synchronous RAM; rdata updates only on an enabled read.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the loader masks unwritten words.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Loadable program memory: BOOT-phase image load with checksum, RUN-phase
// 1-cycle fetch through a req/ready/valid handshake.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic [DATA_W-1:0] load_sum,
  output logic              load_err,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic              running
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  state_t            state;
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic              load_in_range;
  logic              fetch_in_range;
  logic              wr_ok;
  logic              wr_bad;
  logic              accept;
  logic              rd_mask_q;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  ram_addr;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  assign load_idx       = load_addr[IDX_W-1:0];
  assign fetch_idx      = fetch_addr[IDX_W-1:0];
  assign load_in_range  = 32'(load_addr) < DEPTH;
  assign fetch_in_range = 32'(fetch_addr) < DEPTH;

  // Writes only in BOOT, reads only in RUN, so the single port never conflicts.
  assign wr_ok    = (state == ST_BOOT) && load_we && load_in_range;
  assign wr_bad   = (state == ST_BOOT) && load_we && !load_in_range;
  assign accept   = fetch_req && fetch_ready;
  assign ram_en   = wr_ok || (accept && fetch_in_range);
  assign ram_addr = (state == ST_BOOT) ? load_idx : fetch_idx;

  prog_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (wr_ok),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  // A load_start clear applies before a same-cycle write is marked valid.
  always_comb begin
    valid_d = load_start ? '0 : valid_q;
    if (wr_ok) begin
      valid_d[load_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BOOT;
      running     <= 1'b0;
      fetch_ready <= 1'b0;
      valid_q     <= '0;
      load_sum    <= '0;
      load_err    <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      rd_mask_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;

      if (load_start) begin
        state       <= ST_BOOT;
        running     <= 1'b0;
        fetch_ready <= 1'b0;
      end else if (load_done && (state == ST_BOOT)) begin
        state       <= ST_RUN;
        running     <= 1'b1;
        fetch_ready <= 1'b1;
      end

      if (load_start) begin
        load_sum <= wr_ok ? load_data : '0;
        load_err <= wr_bad;
      end else begin
        if (wr_ok) begin
          load_sum <= load_sum + load_data;
        end
        if (wr_bad) begin
          load_err <= 1'b1;
        end
      end

      // An in-flight fetch completes even if load_start lands in its accept cycle.
      fetch_valid <= accept;
      fetch_err   <= accept && !fetch_in_range;
      if (accept) begin
        rd_mask_q <= fetch_in_range && valid_q[fetch_idx];
      end
    end
  end

  // RAM rdata and the mask both change only on an accept, so data holds between valids.
  assign fetch_data = rd_mask_q ? ram_rdata : '0;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader built with DEPTH=16.
module tb_prog_mem_loader;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 16;

  typedef struct packed {
    int                cyc;
    logic              err;
    logic [DATA_W-1:0] data;
  } fetch_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic              load_we = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_done = 1'b0;
  logic [DATA_W-1:0] load_sum;
  logic              load_err;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;
  logic              running;

  fetch_t exp_q[$];
  fetch_t got_q[$];
  fetch_t e;
  fetch_t g;
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  prog_mem_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_done   (load_done),
    .load_sum    (load_sum),
    .load_err    (load_err),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .running     (running)
  );

  always #5 clk = ~clk;

  // Advance one cycle and record any fetch result the DUT produced.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (fetch_valid) got_q.push_back('{cyc: cyc, err: fetch_err, data: fetch_data});
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic pulse_done();
    load_done = 1'b1; tick(); load_done = 1'b0;
  endtask

  task automatic fetch_cycle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ed,
                             input logic ee);
    fetch_req = 1'b1; fetch_addr = a;
    exp_q.push_back('{cyc: cyc + 1, err: ee, data: ed});
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", fetch_ready); end
    n_cmp++; if (load_sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", load_sum); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    n_cmp++; if (fetch_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", fetch_data); end
    #10 reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = 5'h00;
    for (int i = 0; i < 3; i++) tick();
    fetch_req = 1'b0;
    tick();
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL boot_fetch_ignored: got %0d valids want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_boot_fetch();
    load(5'h00, 8'hBF);
    load(5'h01, 8'h5E);
    load(5'h02, 8'hDA);
    n_cmp++; if (load_sum !== 8'hF7) begin n_fail++; $display("FAIL boot_sum: got %h want f7", load_sum); end
    pulse_done();
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL boot_running: got %b want 1", running); end
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL boot_ready: got %b want 1", fetch_ready); end
    fetch_cycle(5'h00, 8'hBF, 1'b0);
    fetch_cycle(5'h01, 8'h5E, 1'b0);
    fetch_cycle(5'h02, 8'hDA, 1'b0);
    tick();
    n_cmp++; if (fetch_data !== 8'hDA) begin n_fail++; $display("FAIL boot_hold: got %h want da", fetch_data); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL boot_fetch: missing valid, want cyc %0d data %h err %b", e.cyc, e.data, e.err); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL boot_fetch: got cyc %0d data %h err %b, want cyc %0d data %h err %b", g.cyc, g.data, g.err, e.cyc, e.data, e.err); end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL boot_fetch_extra: got %0d extra valids want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_unwritten();
    fetch_cycle(5'h0D, 8'h00, 1'b0);
    fetch_cycle(5'h1F, 8'h00, 1'b1);
    tick();
    n_cmp++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL unwritten_err_drop: got %b want 0", fetch_err); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL unwritten: missing valid, want cyc %0d data %h err %b", e.cyc, e.data, e.err); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL unwritten: got cyc %0d data %h err %b, want cyc %0d data %h err %b", g.cyc, g.data, g.err, e.cyc, e.data, e.err); end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL unwritten_extra: got %0d extra valids want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_bad_load();
    pulse_start();
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL bad_running: got %b want 0", running); end
    n_cmp++; if (load_sum !== 8'h00) begin n_fail++; $display("FAIL bad_clear_sum: got %h want 00", load_sum); end
    load(5'h03, 8'h11);
    load(5'h12, 8'h55);
    n_cmp++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", load_err); end
    n_cmp++; if (load_sum !== 8'h11) begin n_fail++; $display("FAIL bad_sum: got %h want 11", load_sum); end
    load(5'h04, 8'h80);
    load(5'h04, 8'h80);
    n_cmp++; if (load_sum !== 8'h11) begin n_fail++; $display("FAIL bad_wrap_sum: got %h want 11", load_sum); end
    n_cmp++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL bad_sticky: got %b want 1", load_err); end
    pulse_start();
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_clear: got %b want 0", load_err); end
    n_cmp++; if (load_sum !== 8'h00) begin n_fail++; $display("FAIL bad_sum_clear: got %h want 00", load_sum); end
    pulse_done();
    load(5'h05, 8'h77);
    n_cmp++; if (load_sum !== 8'h00) begin n_fail++; $display("FAIL run_write_sum: got %h want 00", load_sum); end
    fetch_cycle(5'h03, 8'h00, 1'b0);
    fetch_cycle(5'h04, 8'h00, 1'b0);
    fetch_cycle(5'h00, 8'h00, 1'b0);
    fetch_cycle(5'h05, 8'h00, 1'b0);
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL bad_load: missing valid, want cyc %0d data %h err %b", e.cyc, e.data, e.err); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL bad_load: got cyc %0d data %h err %b, want cyc %0d data %h err %b", g.cyc, g.data, g.err, e.cyc, e.data, e.err); end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL bad_load_extra: got %0d extra valids want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_simultaneous();
    pulse_start();
    load_start = 1'b1; load_we = 1'b1; load_addr = 5'h05; load_data = 8'h3C;
    tick();
    load_start = 1'b0; load_we = 1'b0;
    n_cmp++; if (load_sum !== 8'h3C) begin n_fail++; $display("FAIL sim_start_we_sum: got %h want 3c", load_sum); end
    load_done = 1'b1; load_we = 1'b1; load_addr = 5'h06; load_data = 8'h42;
    tick();
    load_done = 1'b0; load_we = 1'b0;
    n_cmp++; if (load_sum !== 8'h7E) begin n_fail++; $display("FAIL sim_done_we_sum: got %h want 7e", load_sum); end
    n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL sim_done_running: got %b want 1", running); end
    fetch_cycle(5'h06, 8'h42, 1'b0);
    fetch_cycle(5'h05, 8'h3C, 1'b0);
    fetch_req = 1'b1; fetch_addr = 5'h06; load_start = 1'b1;
    exp_q.push_back('{cyc: cyc + 1, err: 1'b0, data: 8'h42});
    tick();
    load_start = 1'b0; fetch_addr = 5'h05;
    n_cmp++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL sim_ready_drop: got %b want 0", fetch_ready); end
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL sim_running_drop: got %b want 0", running); end
    n_cmp++; if (load_sum !== 8'h00) begin n_fail++; $display("FAIL sim_sum_clear: got %h want 00", load_sum); end
    tick();
    tick();
    fetch_req = 1'b0;
    load_start = 1'b1; load_done = 1'b1;
    tick();
    load_start = 1'b0; load_done = 1'b0;
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL sim_start_wins: got %b want 0", running); end
    pulse_done();
    fetch_cycle(5'h05, 8'h00, 1'b0);
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL simultaneous: missing valid, want cyc %0d data %h err %b", e.cyc, e.data, e.err); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL simultaneous: got cyc %0d data %h err %b, want cyc %0d data %h err %b", g.cyc, g.data, g.err, e.cyc, e.data, e.err); end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL simultaneous_extra: got %0d extra valids want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    load(5'h07, 8'h99);
    pulse_done();
    fetch_cycle(5'h07, 8'h99, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", fetch_valid); end
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL areset_running: got %b want 0", running); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready: got %b want 0", fetch_ready); end
    n_cmp++; if (load_sum !== 8'h00) begin n_fail++; $display("FAIL areset_sum: got %h want 00", load_sum); end
    n_cmp++; if (fetch_data !== 8'h00) begin n_fail++; $display("FAIL areset_data: got %h want 00", fetch_data); end
    #2 reset = 1'b0;
    pulse_done();
    fetch_cycle(5'h07, 8'h00, 1'b0);
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL async_reset: missing valid, want cyc %0d data %h err %b", e.cyc, e.data, e.err); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL async_reset: got cyc %0d data %h err %b, want cyc %0d data %h err %b", g.cyc, g.data, g.err, e.cyc, e.data, e.err); end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL async_reset_extra: got %0d extra valids want 0", got_q.size()); got_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_unwritten();
    test_bad_load();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
